// File: rtl/ctrl_pkg.sv
// Shared types and codes for the multi-cycle RV32I control unit:
// FSM states, opcodes, mux/immediate/ALU select encodings.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR_PC,
    S_LUI,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_JALR = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_READ   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       retire;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    alu_op_t    alu_op;
  } ctrl_t;

  // Branch funct3 other than beq/bne is unsupported.
  function automatic state_t decode_next(
    input logic [6:0] op,
    input logic [1:0] f3hi
  );
    state_t s;
    s = S_TRAP;
    case (op)
      OP_LOAD,
      OP_STORE:  s = S_MEMADR;
      OP_R:      s = S_EXECR;
      OP_I:      s = S_EXECI;
      OP_BRANCH: s = (f3hi == 2'b00) ? S_BRANCH : S_TRAP;
      OP_JAL:    s = S_JAL;
      OP_JALR:   s = S_JALR;
      OP_LUI:    s = S_LUI;
      default:   s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: alu_op, funct3, funct7[5], opcode[5]
// -> 4-bit alu_control.
import ctrl_pkg::*;

module alu_decoder (
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates sub from addi with imm[10] set
          3'b000: alu_control =
            (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control =
            funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM driving the shared datapath.
// In: instr, zero, mem_ready. Out: strobes, mux selects, retire, illegal.
import ctrl_pkg::*;

module multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [2:0]  imm_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_control,
  output logic [1:0]  result_src,
  output logic        retire,
  output logic        illegal
);

  state_t state_q;
  state_t state_d;
  ctrl_t  c;

  logic [6:0] op;
  logic       is_branch;
  logic       is_jal;
  logic       unused_ok;

  assign op        = instr[6:0];
  assign is_branch = (op == OP_BRANCH);
  assign is_jal    = (op == OP_JAL);
  assign unused_ok = ^{instr[31], instr[29:15],
                       instr[11:7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
      S_DECODE:
        state_d = decode_next(op, instr[14:13]);
      S_MEMADR:
        state_d = instr[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:
        if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWRITE:
        if (mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_JAL,
      S_JALR_PC,
      S_LUI:     state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JALR:    state_d = S_JALR_PC;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    c.alu_op = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURES;
        c.ir_write   = mem_ready;
        c.pc_write   = mem_ready;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        unique case (1'b1)
          is_branch: c.imm_src = IMM_B;
          is_jal:    c.imm_src = IMM_J;
          default:   c.imm_src = IMM_I;
        endcase
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = instr[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_READ;
        c.reg_write  = 1'b1;
        c.retire     = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.adr_src = 1'b1;
        c.retire  = mem_ready;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_RD2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = IMM_I;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
        c.retire     = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = SRCA_RD1;
        c.alu_src_b  = SRCB_RD2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        // funct3[0] flips beq into bne
        c.pc_write   = zero ^ instr[12];
        c.retire     = 1'b1;
      end
      S_JAL,
      S_JALR_PC: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALUOUT;
        c.pc_write   = 1'b1;
      end
      S_JALR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = IMM_JALR;
      end
      S_LUI: begin
        c.alu_src_a = SRCA_ZERO;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = IMM_U;
      end
      default: c = '0;
    endcase
  end

  alu_decoder u_alu_dec (
    .alu_op      (c.alu_op),
    .funct3      (instr[14:12]),
    .funct7b5    (instr[30]),
    .op5         (instr[5]),
    .alu_control (alu_control)
  );

  // Strobes drop the instant reset asserts, before state settles.
  assign mem_req    = c.mem_req   & rst_n;
  assign mem_we     = c.mem_we    & rst_n;
  assign ir_write   = c.ir_write  & rst_n;
  assign pc_write   = c.pc_write  & rst_n;
  assign reg_write  = c.reg_write & rst_n;
  assign retire     = c.retire    & rst_n;
  assign adr_src    = c.adr_src;
  assign imm_src    = c.imm_src;
  assign alu_src_a  = c.alu_src_a;
  assign alu_src_b  = c.alu_src_b;
  assign result_src = c.result_src;
  assign illegal    = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction step model,
// random instruction/handshake stimulus, directed literal checks.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, adr_src, ir_write;
  logic        pc_write, reg_write, retire, illegal;
  logic [2:0]  imm_src;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [3:0]  alu_control;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we),
    .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write),
    .imm_src(imm_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control),
    .result_src(result_src), .retire(retire),
    .illegal(illegal)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [2:0] imm;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] alu;
    logic [1:0] rs;
    logic       retire;
    logic       illegal;
  } ov_t;

  // wt: waits for mem_ready; fl: fetch strobes follow mem_ready;
  // wr: retire follows mem_ready; br: pc_write = zero ^ funct3[0]
  typedef struct {
    ov_t o;
    bit  wt;
    bit  fl;
    bit  wr;
    bit  br;
  } step_t;

  ov_t   act;
  step_t steps[$];
  string names[$];
  ov_t   rec[$];
  bit    rq[$];
  int    checks = 0;
  int    failures = 0;

  assign act = {mem_req, mem_we, adr_src, ir_write,
                pc_write, reg_write, imm_src, alu_src_a,
                alu_src_b, alu_control, result_src,
                retire, illegal};

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               nm, a, e);
    end
  endtask

  function automatic ov_t mk(input logic [1:0] a,
                             input logic [1:0] b,
                             input logic [3:0] alu,
                             input logic [2:0] imm,
                             input logic [1:0] rs);
    ov_t v;
    v = '0;
    v.a = a; v.b = b; v.alu = alu;
    v.imm = imm; v.rs = rs;
    return v;
  endfunction

  function automatic logic [3:0] alu_of(
    input logic [6:0] op, input logic [2:0] f3,
    input logic b30);
    logic [3:0] r;
    case (f3)
      3'd0: r = (op == 7'h33 && b30) ? 4'd1 : 4'd0;
      3'd1: r = 4'd6;
      3'd2: r = 4'd5;
      3'd3: r = 4'd9;
      3'd4: r = 4'd4;
      3'd5: r = b30 ? 4'd8 : 4'd7;
      3'd6: r = 4'd3;
      default: r = 4'd2;
    endcase
    return r;
  endfunction

  function automatic bit legal(input logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h23, 7'h33, 7'h13,
      7'h6F, 7'h67, 7'h37: return 1'b1;
      7'h63: return (w[14:13] == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input string nm, input ov_t o,
                      input bit wt, input bit fl,
                      input bit wr, input bit br);
    step_t s;
    s.o = o; s.wt = wt; s.fl = fl;
    s.wr = wr; s.br = br;
    steps.push_back(s);
    names.push_back(nm);
  endtask

  task automatic build(input logic [31:0] w);
    logic [6:0] op;
    ov_t v, wb;
    op = w[6:0];
    steps.delete();
    names.delete();
    v = mk(2'd0, 2'd2, 4'd0, 3'd0, 2'd2);
    v.mem_req = 1'b1;
    push("fetch", v, 1, 1, 0, 0);
    push("decode", mk(2'd1, 2'd1, 4'd0,
         (op == 7'h63) ? 3'd2 :
         (op == 7'h6F) ? 3'd4 : 3'd0, 2'd0),
         0, 0, 0, 0);
    if (!legal(w)) return;
    wb = '0;
    wb.reg_write = 1'b1;
    wb.retire = 1'b1;
    case (op)
      7'h03: begin
        push("memadr", mk(2'd2, 2'd1, 4'd0, 3'd0, 2'd0),
             0, 0, 0, 0);
        v = '0; v.mem_req = 1'b1; v.adr_src = 1'b1;
        push("memread", v, 1, 0, 0, 0);
        v = wb; v.rs = 2'd1;
        push("memwb", v, 0, 0, 0, 0);
      end
      7'h23: begin
        push("memadr", mk(2'd2, 2'd1, 4'd0, 3'd1, 2'd0),
             0, 0, 0, 0);
        v = '0; v.mem_req = 1'b1;
        v.mem_we = 1'b1; v.adr_src = 1'b1;
        push("memwrite", v, 1, 0, 1, 0);
      end
      7'h33: begin
        push("execr", mk(2'd2, 2'd0,
             alu_of(op, w[14:12], w[30]), 3'd0, 2'd0),
             0, 0, 0, 0);
        push("aluwb", wb, 0, 0, 0, 0);
      end
      7'h13: begin
        push("execi", mk(2'd2, 2'd1,
             alu_of(op, w[14:12], w[30]), 3'd0, 2'd0),
             0, 0, 0, 0);
        push("aluwb", wb, 0, 0, 0, 0);
      end
      7'h63: begin
        v = mk(2'd2, 2'd0, 4'd1, 3'd0, 2'd0);
        v.retire = 1'b1;
        push("branch", v, 0, 0, 0, 1);
      end
      7'h6F: begin
        v = mk(2'd1, 2'd2, 4'd0, 3'd0, 2'd0);
        v.pc_write = 1'b1;
        push("jal", v, 0, 0, 0, 0);
        push("aluwb", wb, 0, 0, 0, 0);
      end
      7'h67: begin
        push("jalr", mk(2'd2, 2'd1, 4'd0, 3'd5, 2'd0),
             0, 0, 0, 0);
        v = mk(2'd1, 2'd2, 4'd0, 3'd0, 2'd0);
        v.pc_write = 1'b1;
        push("jalr_pc", v, 0, 0, 0, 0);
        push("aluwb", wb, 0, 0, 0, 0);
      end
      default: begin
        push("lui", mk(2'd3, 2'd1, 4'd0, 3'd3, 2'd0),
             0, 0, 0, 0);
        push("aluwb", wb, 0, 0, 0, 0);
      end
    endcase
  endtask

  function automatic logic [6:0] strobes();
    return {mem_req, mem_we, ir_write, pc_write,
            reg_write, retire, illegal};
  endfunction

  // Starts and ends at posedge+1.
  task automatic run(input logic [31:0] w, input bit dir,
                     input logic zf, input int abort_cyc);
    int idx, cyc, waits;
    bit adv;
    ov_t e;
    build(w);
    instr = w;
    rec.delete();
    idx = 0; cyc = 0; waits = 0;
    while (idx < steps.size()) begin
      if (dir) begin
        mem_ready = (rq.size() > 0) ? rq.pop_front() : 1'b1;
        zero = zf;
      end else begin
        mem_ready = ($urandom_range(0, 99) < 55) ||
                    (waits >= 4);
        zero = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
      e = steps[idx].o;
      if (steps[idx].fl && mem_ready) begin
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
      end
      if (steps[idx].wr && mem_ready) e.retire = 1'b1;
      if (steps[idx].br && (zero ^ w[12]))
        e.pc_write = 1'b1;
      chk(names[idx], 32'(act), 32'(e));
      rec.push_back(act);
      if (cyc == abort_cyc) begin
        #2 rst_n = 1'b0;
        #1 chk("abort_strobes", 32'(strobes()), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      adv = !steps[idx].wt || mem_ready;
      @(posedge clk);
      #1;
      if (adv) begin idx++; waits = 0; end
      else waits++;
    end
  endtask

  task automatic trap_and_reset();
    ov_t e;
    e = '0;
    e.illegal = 1'b1;
    for (int i = 0; i < 12; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("trap", 32'(act), 32'(e));
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1 chk("trap_reset", 32'(strobes()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    int n, k;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_strobes", 32'(strobes()), 32'd0);
    rst_n = 1'b1;

    run(32'h002081B3, 1, 1'b0, 0);
    chk("add_alu_c3", 32'(rec[2].alu), 32'd0);
    chk("add_regw_c4", 32'(rec[3].reg_write), 32'd1);
    chk("add_retire_c4", 32'(rec[3].retire), 32'd1);
    chk("add_len", rec.size(), 32'd4);

    rq = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
    run(32'h0080A283, 1, 1'b0, 0);
    n = 0; k = 0;
    foreach (rec[i]) begin
      n += int'(rec[i].ir_write);
      k += int'(rec[i].pc_write);
    end
    chk("lw_irw_pulses", n, 32'd1);
    chk("lw_pcw_pulses", k, 32'd1);
    chk("lw_imm_memadr", 32'(rec[5].imm), 32'd0);
    chk("lw_regw_c10", 32'(rec[9].reg_write), 32'd1);
    chk("lw_len", rec.size(), 32'd10);

    run(32'h0080A283, 1, 1'b0, 4);
    run(32'h002081B3, 1, 1'b0, 0);
    chk("post_rst_memreq", 32'(rec[0].mem_req), 32'd1);
    chk("post_rst_adr", 32'(rec[0].adr_src), 32'd0);

    run(32'h00208863, 1, 1'b1, 0);
    chk("beq_imm_dec", 32'(rec[1].imm), 32'd2);
    chk("beq_z1_pcw", 32'(rec[2].pc_write), 32'd1);
    chk("beq_len", rec.size(), 32'd3);
    run(32'h00208863, 1, 1'b0, 0);
    chk("beq_z0_pcw", 32'(rec[2].pc_write), 32'd0);
    run(32'h00209863, 1, 1'b0, 0);
    chk("bne_z0_pcw", 32'(rec[2].pc_write), 32'd1);

    run(32'h000100E7, 1, 1'b0, 0);
    chk("jalr_imm", 32'(rec[2].imm), 32'd5);
    chk("jalr_pcw_c4", 32'(rec[3].pc_write), 32'd1);
    chk("jalr_regw_c5", 32'(rec[4].reg_write), 32'd1);
    chk("jalr_retire_c5", 32'(rec[4].retire), 32'd1);

    run(32'h0000007F, 1, 1'b0, 0);
    trap_and_reset();

    for (int t = 0; t < 300; t++) begin
      k = $urandom_range(0, 19);
      w = $urandom;
      case (k)
        0, 1:   begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
        2, 3:   begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
        4, 5, 6: w[6:0] = 7'h33;
        7, 8, 9: w[6:0] = 7'h13;
        10, 11: begin
          w[6:0] = 7'h63;
          w[14:13] = 2'b00;
        end
        12, 13: w[6:0] = 7'h6F;
        14, 15: begin w[6:0] = 7'h67; w[14:12] = 3'd0; end
        16, 17: w[6:0] = 7'h37;
        18: begin
          w[6:0] = 7'h63;
          w[14:12] = 3'($urandom_range(2, 7));
        end
        default: begin
          while (legal(w)) w = $urandom;
        end
      endcase
      run(w, 0, 1'b0, 0);
      if (!legal(w)) trap_and_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle RV32I control unit that sequences the shared datapath (one memory port, one ALU, the immediate extender) across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. It consumes the latched instruction, the ALU zero flag and a memory ready handshake. It drives every datapath strobe and mux select, including the 3-bit immediate-format select into the sign extender. It replaces the single-cycle decoder when the core moves to the shared-memory multi-cycle datapath.

## Interface
- No parameters; widths fixed by RV32I.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- instr  in  32  instruction register contents, stable from DECODE until FETCH
- zero  in  1  ALU zero flag, combinational in current cycle
- mem_ready  in  1  memory completed current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write request (valid with mem_req)
- adr_src  out  1  address select: 0 PC, 1 ALUOut
- ir_write  out  1  latch instr/OldPC
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register-file write
- imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 jalr
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1, 11 zero
- alu_src_b  out  2  00 RD2, 01 ImmExt, 10 constant 4
- alu_control  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu
- result_src  out  2  00 ALUOut, 01 read data, 10 ALUResult
- retire  out  1  one-cycle pulse in final state of each instruction
- illegal  out  1  sticky unsupported-opcode flag

## Operation
- Supported: lw, sw, R-ALU, I-ALU, beq/bne, jal, jalr, lui. Any other opcode, or branch funct3 not 000/001, is illegal.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, add, result_src=10; ir_write=pc_write=mem_ready; stay until mem_ready, then DECODE.
- DECODE: a=01, b=01, add (target into ALUOut); imm_src from opcode: branch 010, jal 100, else 000. Next: MEMADR (lw/sw), EXECR, EXECI, BRANCH, JAL, JALR, LUI, or TRAP.
- MEMADR: a=10, b=01, add, imm_src 000 (lw) or 001 (sw) -> MEMREAD / MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1; hold until mem_ready -> MEMWB.
- MEMWB: result_src=01, reg_write, retire -> FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1; on mem_ready retire -> FETCH.
- EXECR: a=10, b=00, alu from funct3/funct7[5] -> ALUWB. EXECI: a=10, b=01, imm 000, funct7[5] honoured only for srai -> ALUWB.
- ALUWB: result_src=00, reg_write, retire -> FETCH.
- BRANCH: a=10, b=00, sub, result_src=00; pc_write = zero XOR funct3[0]; retire -> FETCH.
- JAL: a=01, b=10, add, result_src=00, pc_write -> ALUWB.
- JALR: a=10, b=01, imm 101, add -> JALR_PC: a=01, b=10, add, result_src=00, pc_write -> ALUWB.
- LUI: a=11, b=01, imm 011, add -> ALUWB.
- TRAP: illegal=1, all strobes 0, terminal until reset.
- Unlisted strobes are 0 in every state; unlisted selects are 0.

## Timing
- Reset: state FETCH, illegal=0; while rst_n low all strobes forced 0 combinationally. mem_req asserts in first cycle after release.
- Moore outputs, except: FETCH ir_write/pc_write (mem_ready), BRANCH pc_write (zero), DECODE/MEMADR imm_src (instr).
- mem_ready is ignored outside FETCH/MEMREAD/MEMWRITE. Request is held with stable address until mem_ready.
- Cycles with zero wait: branch 3; R/I/sw/jal/lui 4; lw/jalr 5. Each wait cycle adds 1.
- Reset mid-instruction aborts immediately; no write strobe is issued after rst_n falls.

## Structure
- Package ctrl_pkg: state enum, opcode constants, imm_src/alu_control/mux select codes.
- Sub-module alu_decoder (combinational): alu_op {add, sub, funct} plus funct3, funct7[5], opcode[5] -> alu_control.

## Test plan
- Assert rst_n low during MEMREAD -> all strobes 0 at once, illegal 0. After release, mem_req=1 and adr_src=0 in cycle 1.
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH, DECODE, EXECR (alu_control 0000), ALUWB (reg_write). retire in cycle 4.
- lw x5,8(x1) (0x0080A283), mem_ready delayed 3 cycles in FETCH and 2 in MEMREAD -> single ir_write/pc_write pulse; imm_src 000 in MEMADR; reg_write in cycle 10.
- beq (0x00208863) with zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0. bne with zero=0 -> pc_write=1. imm_src 010 in DECODE.
- jalr x1,0(x2) (0x000100E7) -> imm_src 101 in JALR, pc_write in JALR_PC, reg_write in ALUWB; retire in cycle 5.
- Opcode 0x7F -> TRAP after DECODE; illegal=1 and mem_req=0 for 10+ cycles; rst_n pulse clears illegal.
